mul_approx_pipe: RTL and testbench

//   Parametrised, pipelined unsigned approximate multiplier with a per-operation truncation level.

---
 rtl/mul_approx_if.sv | 31 +++
 rtl/mul_approx_pipe.sv | 116 +++++++++++
 tb/tb_mul_approx_pipe.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mul_approx_if.sv
// mul_approx_if: operand/result handshake bundle for mul_approx_pipe.
//   slave  : the multiplier (consumes operands, produces results)
//   master : operand source + result consumer
//   in_valid/in_ready/in_a/in_b/approx_k : operand beat
//   out_valid/out_ready/out_prod/out_err : result beat
interface mul_approx_if #(
  parameter int WIDTH     = 8,
  parameter int TRUNC_MAX = 8
);
  localparam int KW = $clog2(TRUNC_MAX + 1);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [KW-1:0]      approx_k;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic [2*WIDTH-1:0] out_err;

  modport master (
    output in_valid, in_a, in_b, approx_k, out_ready,
    input  in_ready, out_valid, out_prod, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, approx_k, out_ready,
    output in_ready, out_valid, out_prod, out_err
  );
endinterface

// File: rtl/mul_approx_pipe.sv
// mul_approx_pipe: pipelined unsigned approximate multiplier with per-beat
// truncation level K. Partial-product columns below K are dropped and
// 2^(K-1) is added back; the exact product is computed alongside so each
// result carries |approx - exact|.
//   clk, rst     : clock, async active-high reset
//   bus (slave)  : operand beat in, result beat out (valid/ready both sides)
//   clear_stats  : synchronous clear of txn_cnt/err_max (beats a handshake)
//   txn_cnt      : completed output handshakes, wraps
//   err_max      : largest out_err since reset/clear
module mul_approx_pipe #(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 2,
  parameter int TRUNC_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_approx_if.slave          bus,
  input  logic                 clear_stats,
  output logic [31:0]          txn_cnt,
  output logic [2*WIDTH-1:0]   err_max
);
  localparam int KW = $clog2(TRUNC_MAX + 1);
  localparam int PW = 2 * WIDTH;

  // ---------------- arithmetic (evaluated on the incoming beat) -------------
  logic [KW-1:0] k_eff;
  logic [PW-1:0] exact_p, trunc_p, approx_p, err_p;

  always_comb begin
    k_eff = (bus.approx_k > KW'(TRUNC_MAX)) ? KW'(TRUNC_MAX) : bus.approx_k;
    exact_p = PW'(bus.in_a) * PW'(bus.in_b);
    trunc_p = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        if ((i + j) >= int'(k_eff) && bus.in_a[i] && bus.in_b[j])
          trunc_p = trunc_p + (PW'(1) << (i + j));
    approx_p = trunc_p + ((k_eff != '0) ? (PW'(1) << (k_eff - KW'(1))) : '0);
    // zero operand forces zero, compensation included
    if (bus.in_a == '0 || bus.in_b == '0) approx_p = '0;
    err_p = (approx_p >= exact_p) ? (approx_p - exact_p) : (exact_p - approx_p);
  end

  // ---------------- pipeline -------------------------------------------------
  logic [STAGES-1:0]         vld_pipe;
  logic [STAGES-1:0][PW-1:0] prod_q, err_q;
  logic [STAGES-1:0]         src_vld;
  logic [STAGES-1:0][PW-1:0] src_prod, src_err;
  logic [STAGES-1:0]         load;
  logic                      load_acc;

  // A stage loads when it or any stage downstream has a hole, or the
  // consumer is taking the output this cycle.
  always_comb begin
    load     = '0;
    load_acc = bus.out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      load_acc = load_acc || !vld_pipe[s];
      load[s]  = load_acc;
    end
  end

  always_comb begin
    src_vld     = '0;
    src_prod    = '0;
    src_err     = '0;
    src_vld[0]  = bus.in_valid;
    src_prod[0] = approx_p;
    src_err[0]  = err_p;
    for (int s = 1; s < STAGES; s++) begin
      src_vld[s]  = vld_pipe[s-1];
      src_prod[s] = prod_q[s-1];
      src_err[s]  = err_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      prod_q   <= '0;
      err_q    <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (load[s]) begin
          vld_pipe[s] <= src_vld[s];
          // bubbles don't overwrite data, keeps outputs quiet
          if (src_vld[s]) begin
            prod_q[s] <= src_prod[s];
            err_q[s]  <= src_err[s];
          end
        end
      end
    end
  end

  assign bus.in_ready  = !rst && load[0];
  assign bus.out_valid = vld_pipe[STAGES-1];
  assign bus.out_prod  = prod_q[STAGES-1];
  assign bus.out_err   = err_q[STAGES-1];

  // ---------------- stats ----------------------------------------------------
  logic hs;
  assign hs = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt <= '0;
      err_max <= '0;
    end else if (clear_stats) begin
      txn_cnt <= '0;
      err_max <= '0;
    end else if (hs) begin
      txn_cnt <= txn_cnt + 32'd1;
      if (bus.out_err > err_max) err_max <= bus.out_err;
    end
  end
endmodule

// File: tb/tb_mul_approx_pipe.sv
module tb_mul_approx_pipe;
  localparam int WIDTH     = 8;
  localparam int STAGES    = 2;
  localparam int TRUNC_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_stats = 1'b0;
  logic [31:0] txn_cnt;
  logic [15:0] err_max;

  int checks = 0;
  int errors = 0;

  mul_approx_if #(.WIDTH(WIDTH), .TRUNC_MAX(TRUNC_MAX)) bus ();

  mul_approx_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TRUNC_MAX(TRUNC_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .clear_stats (clear_stats),
    .txn_cnt     (txn_cnt),
    .err_max     (err_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  k;
    logic [15:0] prod;
    logic [15:0] err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one beat with out_ready high and return the result and the
  // number of cycles from the accepting edge to out_valid.
  task automatic run_beat(input logic [7:0] a, input logic [7:0] b, input logic [3:0] k,
                          output logic [15:0] p, output logic [15:0] e, output int lat);
    int guard = 0;
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.approx_k = k; bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin @(negedge clk); lat++; end
    p = bus.out_prod;
    e = bus.out_err;
  endtask

  vec_t        vecs[11];
  logic [15:0] p, e, held;
  int          lat, sent, got, seen;
  logic [15:0] rx[5];

  initial begin
    vecs[0]  = '{8'd255, 8'd255, 4'd0,  16'd65025, 16'd0};
    vecs[1]  = '{8'd255, 8'd255, 4'd4,  16'd64984, 16'd41};
    vecs[2]  = '{8'd255, 8'd255, 4'd8,  16'd63360, 16'd1665};
    vecs[3]  = '{8'd0,   8'd200, 4'd3,  16'd0,     16'd0};
    vecs[4]  = '{8'd255, 8'd255, 4'd15, 16'd63360, 16'd1665};
    vecs[5]  = '{8'd3,   8'd5,   4'd1,  16'd15,    16'd0};
    vecs[6]  = '{8'd200, 8'd0,   4'd8,  16'd0,     16'd0};
    vecs[7]  = '{8'd1,   8'd1,   4'd1,  16'd1,     16'd0};
    vecs[8]  = '{8'd1,   8'd1,   4'd2,  16'd2,     16'd1};
    vecs[9]  = '{8'd16,  8'd16,  4'd8,  16'd384,   16'd128};
    vecs[10] = '{8'd15,  8'd15,  4'd4,  16'd184,   16'd41};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.approx_k = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_prod", bus.out_prod, 0);
    chk("rst_txn_cnt", txn_cnt, 0);
    chk("rst_err_max", err_max, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // arithmetic table
    for (int i = 0; i < 11; i++) begin
      run_beat(vecs[i].a, vecs[i].b, vecs[i].k, p, e, lat);
      chk($sformatf("vec%0d_prod", i), p, vecs[i].prod);
      chk($sformatf("vec%0d_err", i), e, vecs[i].err);
      chk($sformatf("vec%0d_latency", i), lat, STAGES);
    end
    @(negedge clk);
    chk("table_txn_cnt", txn_cnt, 11);
    chk("table_err_max", err_max, 1665);

    // stats: clear, three beats, then clear coincident with a handshake
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk("clear_txn_cnt", txn_cnt, 0);
    chk("clear_err_max", err_max, 0);
    run_beat(8'd255, 8'd255, 4'd4, p, e, lat);
    run_beat(8'd255, 8'd255, 4'd8, p, e, lat);
    run_beat(8'd7, 8'd9, 4'd0, p, e, lat);
    @(negedge clk);
    chk("stats_txn_cnt", txn_cnt, 3);
    chk("stats_err_max", err_max, 1665);
    run_beat(8'd255, 8'd255, 4'd8, p, e, lat);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk("clear_hs_txn_cnt", txn_cnt, 0);
    chk("clear_hs_err_max", err_max, 0);
    chk("clear_hs_out_valid", bus.out_valid, 0);

    // backpressure: 5 beats, consumer stalled for the first 6 cycles
    bus.out_ready = 1'b0;
    sent = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      @(negedge clk);
      if (cyc == 6) bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin rx[got] = bus.out_prod; got++; end
      if (cyc == 2) held = bus.out_prod;
      if (cyc == 5) begin
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_prod", bus.out_prod, held);
        chk("bp_first_prod", held, 200);
      end
      if (sent < 5) begin
        bus.in_a = 8'(10 + sent); bus.in_b = 8'(20 + sent); bus.approx_k = '0;
        bus.in_valid = 1'b1;
        if (bus.in_ready) sent++;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (cyc == 5) begin
        chk("bp_accepts", sent, STAGES);
        chk("bp_in_ready_low", bus.in_ready, 0);
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_count", got, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_order%0d", i), rx[i], 16'((10 + i) * (20 + i)));

    // reset with beats in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 10 && sent < 2; cyc++) begin
      @(negedge clk);
      bus.in_a = 8'd33; bus.in_b = 8'd44; bus.approx_k = 4'd2; bus.in_valid = 1'b1;
      if (bus.in_ready) sent++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("midrst_release_in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_stale", seen, 0);
    chk("midrst_txn_cnt", txn_cnt, 0);
    run_beat(8'd255, 8'd255, 4'd4, p, e, lat);
    chk("midrst_new_prod", p, 64984);
    chk("midrst_new_err", e, 41);
    chk("midrst_new_latency", lat, STAGES);
    @(negedge clk);
    chk("midrst_new_txn_cnt", txn_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected completion");
    $fatal(1);
  end
endmodule
